// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter, carry/borrow flags and output-pin source
// select driven by the mov/branch decoder strobes.
// Optional feature macro: BRANCH_FLAG_CLEAR_EN -- when defined, a taken
// branch-on-carry clears carry and a taken branch-on-borrow clears borrow
// (a simultaneous flagWe load still wins).
module pc_branch_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step,
    input  logic            bcf,
    input  logic            bbf,
    input  logic            buc,
    input  logic            toggleOut,
    input  logic [PC_W-1:0] r3,
    input  logic            flagWe,
    input  logic            carryIn,
    input  logic            borrowIn,
    output logic [PC_W-1:0] pc,
    output logic            carry,
    output logic            borrow,
    output logic            outSel,
    output logic [PC_W-1:0] outPins,
    output logic            taken
);

    // Which branch strobe is in effect after priority resolution.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_BUC  = 2'd1,
        SEL_BCF  = 2'd2,
        SEL_BBF  = 2'd3
    } strobe_e;

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pins_r;
    logic            carry_r;
    logic            borrow_r;
    logic            outsel_r;
    logic            taken_r;

    strobe_e         sel_s;
    logic            take_s;
    logic [PC_W-1:0] pc_next_s;
    logic            outsel_next_s;
    logic [PC_W-1:0] pins_next_s;
    logic            clr_carry_s;
    logic            clr_borrow_s;
    logic            carry_next_s;
    logic            borrow_next_s;

    // Resolve simultaneous strobes: unconditional beats carry beats borrow.
    always_comb begin
        sel_s = SEL_NONE;
        if (buc) begin
            sel_s = SEL_BUC;
        end else if (bcf) begin
            sel_s = SEL_BCF;
        end else if (bbf) begin
            sel_s = SEL_BBF;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Branch decision uses the registered (pre-write) flags only.
    always_comb begin
        take_s = 1'b0;
        case (sel_s)
            SEL_BUC: take_s = step;
            SEL_BCF: take_s = step & carry_r;
            SEL_BBF: take_s = step & borrow_r;
            default: take_s = 1'b0;
        endcase
    end

    // Next PC, output select and pin value for a retired instruction.
    always_comb begin
        pc_next_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        if (take_s) begin
            pc_next_s = pc_r + r3;
        end else begin
            pc_next_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
        outsel_next_s = outsel_r ^ (toggleOut & step);
        pins_next_s   = outsel_next_s ? pc_next_s : r3;
    end

    // Optional flag clear on a taken conditional branch.
    always_comb begin
        clr_carry_s  = 1'b0;
        clr_borrow_s = 1'b0;
`ifdef BRANCH_FLAG_CLEAR_EN
        clr_carry_s  = take_s & (sel_s == SEL_BCF);
        clr_borrow_s = take_s & (sel_s == SEL_BBF);
`else
        clr_carry_s  = 1'b0;
        clr_borrow_s = 1'b0;
`endif
    end

    // Flag next state: an ALU load has precedence over a branch clear.
    always_comb begin
        carry_next_s  = carry_r;
        borrow_next_s = borrow_r;
        if (flagWe) begin
            carry_next_s  = carryIn;
            borrow_next_s = borrowIn;
        end else begin
            carry_next_s  = carry_r & ~clr_carry_s;
            borrow_next_s = borrow_r & ~clr_borrow_s;
        end
    end

    // State registers; flags load regardless of step, the rest only on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= {PC_W{1'b0}};
            pins_r   <= {PC_W{1'b0}};
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
            outsel_r <= 1'b0;
            taken_r  <= 1'b0;
        end else begin
            carry_r  <= carry_next_s;
            borrow_r <= borrow_next_s;
            if (step) begin
                pc_r     <= pc_next_s;
                pins_r   <= pins_next_s;
                outsel_r <= outsel_next_s;
                taken_r  <= take_s;
            end else begin
                pc_r     <= pc_r;
                pins_r   <= pins_r;
                outsel_r <= outsel_r;
                taken_r  <= taken_r;
            end
        end
    end

    assign pc      = pc_r;
    assign carry   = carry_r;
    assign borrow  = borrow_r;
    assign outSel  = outsel_r;
    assign outPins = pins_r;
    assign taken   = taken_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table, randomized
// run against a behavioural model, and an asynchronous mid-run reset.
module tb_pc_branch_unit;

`ifdef BRANCH_FLAG_CLEAR_EN
    localparam bit FCLR = 1'b1;
`else
    localparam bit FCLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       step, bcf, bbf, buc, toggleOut, flagWe, carryIn, borrowIn;
    logic [7:0] r3;
    logic [7:0] pc, outPins;
    logic       carry, borrow, outSel, taken;

    int checks   = 0;
    int failures = 0;

    pc_branch_unit #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .step(step), .bcf(bcf), .bbf(bbf), .buc(buc),
        .toggleOut(toggleOut), .r3(r3), .flagWe(flagWe), .carryIn(carryIn),
        .borrowIn(borrowIn), .pc(pc), .carry(carry), .borrow(borrow),
        .outSel(outSel), .outPins(outPins), .taken(taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stp, b_cf, b_bf, b_uc, tog, fwe, cin, bin;
        logic [7:0] r3v;
        logic [7:0] e_pc;
        logic       e_c, e_b, e_sel;
        logic [7:0] e_pins;
        logic       e_tk;
    } vec_t;

    vec_t tbl [22];

    // behavioural model state
    int m_pc, m_pins;
    bit m_c, m_b, m_sel, m_tk;

    function automatic vec_t mk(logic s, logic cf, logic bf, logic uc, logic tg,
                                logic fw, logic ci, logic bi, logic [7:0] rv,
                                logic [7:0] epc, logic ec, logic eb, logic es,
                                logic [7:0] ep, logic et);
        vec_t v;
        v.stp = s; v.b_cf = cf; v.b_bf = bf; v.b_uc = uc; v.tog = tg;
        v.fwe = fw; v.cin = ci; v.bin = bi; v.r3v = rv;
        v.e_pc = epc; v.e_c = ec; v.e_b = eb; v.e_sel = es; v.e_pins = ep; v.e_tk = et;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] epc, input logic ec,
                           input logic eb, input logic es, input logic [7:0] ep,
                           input logic et);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".carry"}, {7'd0, carry}, {7'd0, ec});
        chk({tag, ".borrow"}, {7'd0, borrow}, {7'd0, eb});
        chk({tag, ".outSel"}, {7'd0, outSel}, {7'd0, es});
        chk({tag, ".outPins"}, outPins, ep);
        chk({tag, ".taken"}, {7'd0, taken}, {7'd0, et});
    endtask

    task automatic drive(input logic s, input logic cf, input logic bf, input logic uc,
                         input logic tg, input logic fw, input logic ci, input logic bi,
                         input logic [7:0] rv);
        step = s; bcf = cf; bbf = bf; buc = uc; toggleOut = tg;
        flagWe = fw; carryIn = ci; borrowIn = bi; r3 = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of one clock edge, computed from the current inputs.
    task automatic model_step();
        int  kind;
        bit  take;
        int  off;
        logic signed [7:0] sr;
        kind = buc ? 3 : (bcf ? 1 : (bbf ? 2 : 0));
        take = step && ((kind == 3) || (kind == 1 && m_c) || (kind == 2 && m_b));
        if (step) begin
            sr   = r3;
            off  = take ? int'(sr) : 1;
            m_pc = (((m_pc + off) % 256) + 256) % 256;
            m_sel = m_sel ^ toggleOut;
            m_pins = m_sel ? m_pc : int'(r3);
            m_tk = take;
        end
        if (flagWe) begin
            m_c = carryIn;
            m_b = borrowIn;
        end else if (FCLR && take) begin
            if (kind == 1) m_c = 1'b0;
            if (kind == 2) m_b = 1'b0;
        end
    endtask

    initial begin
        //            stp cf bf uc tg fw ci bi  r3      pc     c      b      sel   pins   tk
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h11, 8'h01, 0, 0, 0, 8'h11, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h22, 8'h02, 0, 0, 0, 8'h22, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0, 8'h00, 0);
        tbl[3]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 8'h0D, 8'h10, 0, 0, 0, 8'h0D, 1);
        tbl[4]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 8'hFC, 8'h0C, 0, 0, 0, 8'hFC, 1);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h0D, 0, 0, 0, 8'h00, 0);
        tbl[6]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 8'hF2, 8'hFF, 0, 0, 0, 8'hF2, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h33, 8'h00, 0, 0, 0, 8'h33, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 8'h40, 8'h01, 1, 0, 0, 8'h40, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 8'h05, 8'h06, !FCLR, 0, 0, 8'h05, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 1, 1, 8'h07, 8'h07, 1, 1, 0, 8'h07, 0);
        tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h10, 8'h07, 1, 1, 0, 8'h07, 0);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h10, 8'h17, 1, !FCLR, 0, 8'h10, 1);
        tbl[13] = mk(1, 0, 0, 0, 1, 0, 0, 0, 8'hA5, 8'h18, 1, !FCLR, 1, 8'h18, 0);
        tbl[14] = mk(1, 0, 0, 0, 1, 0, 0, 0, 8'hA5, 8'h19, 1, !FCLR, 0, 8'hA5, 0);
        tbl[15] = mk(1, 0, 0, 1, 1, 0, 0, 0, 8'h02, 8'h1B, 1, !FCLR, 1, 8'h1B, 1);
        tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 0, 8'h99, 8'h1B, 1, !FCLR, 1, 8'h1B, 1);
        tbl[17] = mk(1, 1, 1, 0, 0, 0, 0, 0, 8'h04, 8'h1F, !FCLR, !FCLR, 1, 8'h1F, 1);
        tbl[18] = mk(1, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 8'h1E, !FCLR, !FCLR, 1, 8'h1E, 1);
        tbl[19] = mk(1, 0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h1F, 0, 1, 1, 8'h1F, 0);
        tbl[20] = mk(1, 1, 0, 0, 0, 0, 0, 0, 8'h10, 8'h20, 0, 1, 1, 8'h20, 0);
        tbl[21] = mk(1, 0, 1, 0, 0, 1, 1, 1, 8'h03, 8'h23, 1, 1, 1, 8'h23, 1);

        // reset state
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tick(); tick();
        chk_all("reset", 8'h00, 0, 0, 0, 8'h00, 0);
        #2 rst = 1'b0;

        // directed table
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].stp, tbl[i].b_cf, tbl[i].b_bf, tbl[i].b_uc, tbl[i].tog,
                  tbl[i].fwe, tbl[i].cin, tbl[i].bin, tbl[i].r3v);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_c, tbl[i].e_b,
                    tbl[i].e_sel, tbl[i].e_pins, tbl[i].e_tk);
        end

        // randomized run; model starts from the table's final state
        m_pc = 'h23; m_c = 1'b1; m_b = 1'b1; m_sel = 1'b1; m_pins = 'h23; m_tk = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int s;
            s = int'($urandom_range(0, 6));
            drive(($urandom_range(0, 3) != 0), (s == 4), (s == 5), (s == 6),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            if (s == 6) begin
                bcf = 1'($urandom);
                bbf = 1'($urandom);
            end
            model_step();
            tick();
            chk_all($sformatf("rnd%0d", n), 8'(m_pc), m_c, m_b, m_sel, 8'(m_pins), m_tk);
        end

        // jump to 0x42, then reset between edges
        drive(1, 0, 0, 1, 0, 0, 0, 0, 8'(8'h42 - 8'(m_pc)));
        tick();
        chk("jump42.pc", pc, 8'h42);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 0, 0, 0, 8'h00, 0);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h5A);
        tick();
        chk_all("post_rst_hold", 8'h00, 0, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h5A);
        tick();
        chk_all("post_rst_step", 8'h01, 0, 0, 0, 8'h5A, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Sequential consumer of the mov/branch decoder's strobes (branch-on-carry, branch-on-borrow, unconditional branch, output toggle). Holds the 8-bit program counter, the registered carry and borrow flags, and the output-pin source select. Each cycle it advances the PC by 1, or by the r3 offset when a branch is taken. It also drives the chip's output pins from r3 or the PC.

## Interface
Parameters:
- `PC_W`, 8: program counter width. Must equal data width; only 8 is supported.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `step` in 1: instruction-retire enable; when low all state holds.
- `bcf` in 1: branch-if-carry strobe from decoder.
- `bbf` in 1: branch-if-borrow strobe from decoder.
- `buc` in 1: unconditional-branch strobe from decoder.
- `toggleOut` in 1: output-source toggle strobe from decoder.
- `r3` in 8: current r3 value; branch offset and pin data.
- `flagWe` in 1: ALU flag write enable.
- `carryIn` in 1: ALU carry result.
- `borrowIn` in 1: ALU borrow result.
- `pc` out 8: registered program counter.
- `carry` out 1: registered carry flag.
- `borrow` out 1: registered borrow flag.
- `outSel` out 1: 0 = pins show r3, 1 = pins show PC.
- `outPins` out 8: registered output pins.
- `taken` out 1: registered; high for one cycle after a retired branch was taken.

## Operation
- Reset values: `pc`=0x00, `carry`=0, `borrow`=0, `outSel`=0, `outPins`=0x00, `taken`=0.
- Branch decision, evaluated only when `step`=1:
  - Unconditional: `buc`.
  - Carry: `bcf` & `carry`.
  - Borrow: `bbf` & `borrow`.
  - Conditions use the registered flags, i.e. the old value, never `carryIn`/`borrowIn` of the same cycle.
- Strobe priority if more than one is high (illegal from decoder, but defined): `buc` > `bcf` > `bbf`.
- PC update when `step`=1:
  - Taken: `pc <= pc + r3`, 8-bit mod-256. r3 is two's complement, so 0xFF is −1 and 0x00 is a self-loop.
  - Not taken: `pc <= pc + 1`, wrapping 0xFF→0x00.
- `step`=0: pc, outSel, outPins and taken hold; flags still load if `flagWe`=1.
- Flags: `flagWe`=1 loads `carry<=carryIn` and `borrow<=borrowIn`.
- Output select: `toggleOut`&`step` flips `outSel`. The toggle is independent of branch strobes and may coincide with them.
- `outPins <= outSel_next ? pc_next : r3` on every `step` cycle. Pins always reflect post-update state.

## Timing
- Branch latency: strobe at edge N → new `pc` visible after edge N, with `taken`=1 for exactly that cycle.
- Flag written at edge N is testable by a branch retired at edge N+1 or later.
- Simultaneous flag write and conditional branch in one cycle: branch tests the pre-write flag; the flag still updates.
- Reset assertion mid-operation clears all state immediately, without a clock. First update after deassertion occurs on the first `clk` edge with `step`=1.
- No combinational path from inputs to outputs.

## Configuration
- `BRANCH_FLAG_CLEAR_EN`:
  - Defined: a taken `bcf` clears `carry` and a taken `bbf` clears `borrow` at the same edge.
  - A simultaneous `flagWe` load wins over the clear.
  - Undefined: flags change only via `flagWe`.

## Test plan
- Reset then 3 cycles `step`=1, no strobes → `pc`=0x03, `outPins`=0x00-sourced r3, `taken`=0.
- `pc`=0x10, `buc`=1, `r3`=0xFC → `pc`=0x0C, `taken`=1 for one cycle; `pc`=0xFF with no strobe → 0x00.
- `carry`=0, then `bcf`=1 in the same cycle as `flagWe`=1/`carryIn`=1 → not taken (`pc`+1); next `bcf`, `r3`=0x05 → taken, +5. With `BRANCH_FLAG_CLEAR_EN`, `carry`=0 afterwards.
- `borrow`=1, `bbf`=1, `step`=0 → `pc` unchanged, `taken`=0; `step`=1 → taken.
- `toggleOut` with `r3`=0xA5 → `outSel`=1, `outPins`=pc; second `toggleOut` → `outPins`=0xA5.
- Assert `rst` between edges while `pc`=0x42 → all outputs zero immediately, before next `clk`.
